// File: rtl/multicycle_control_fsm_pkg.sv
// mcpu_ctrl_pkg: state encoding, ALU codes, opcode/funct constants and mux encodings
// shared by the multicycle MIPS control FSM and its datapath.
package mcpu_ctrl_pkg;
  localparam int CNT_W = $clog2(16);
  typedef enum logic [4:0] {
    RESET = 5'd0, FETCH, MEM_WAIT, IR_WRITE, DECODE, EXEC_R, WB_R, BRANCH, ADDR,
    LW_RD, LW_WAIT, LW_WB, SW_WR, LUI_WB, JUMP, EXC, BREAK
  } state_t;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_NOP   = 6'h00;
  localparam logic [5:0] FN_BREAK = 6'h0D;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_EXC    = 2'b11;
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_LUI    = 2'b10;
  function automatic logic [2:0] functAlu(input logic [5:0] f);
    return f == FN_SUB ? ALU_SUB : f == FN_AND ? ALU_AND : f == FN_XOR ? ALU_XOR : ALU_ADD;
  endfunction
endpackage

// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if: IR fields, ALU flags and datapath control enables between
// the control FSM (master) and the datapath (slave).
interface multicycle_control_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic aluZero;
  logic aluOverflow;
  logic memWriteOrRead;
  logic iorD;
  logic irWrite;
  logic mdrWrite;
  logic pcControl;
  logic pcCond;
  logic bneORbeq;
  logic [1:0] origPC;
  logic writeA;
  logic writeB;
  logic aluSrcA;
  logic [1:0] aluSrcB;
  logic [2:0] aluControl;
  logic aluOutControl;
  logic regWrite;
  logic regDst;
  logic [1:0] memToReg;
  logic epcWrite;
  logic halted;
  logic [4:0] estado;
  modport master (
    input opcode, funct, aluZero, aluOverflow,
    output memWriteOrRead, iorD, irWrite, mdrWrite, pcControl, pcCond, bneORbeq, origPC,
    writeA, writeB, aluSrcA, aluSrcB, aluControl, aluOutControl, regWrite, regDst,
    memToReg, epcWrite, halted, estado
  );
  modport slave (
    output opcode, funct, aluZero, aluOverflow,
    input memWriteOrRead, iorD, irWrite, mdrWrite, pcControl, pcCond, bneORbeq, origPC,
    writeA, writeB, aluSrcA, aluSrcB, aluControl, aluOutControl, regWrite, regDst,
    memToReg, epcWrite, halted, estado
  );
endinterface

// File: rtl/multicycle_control_fsm_mem_wait_counter.sv
// mem_wait_counter: down-counter timing the memory latency; loaded with LOAD, done at zero.
module mem_wait_counter
  import mcpu_ctrl_pkg::*;
#(
  parameter int LOAD = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic count,
  output logic done
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else if (load) cnt <= CNT_W'(LOAD);
    else if (count && cnt != '0) cnt <= cnt - 1'b1;
  end
  assign done = cnt == '0;
endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: Moore control FSM sequencing the multicycle MIPS datapath,
// with variable memory latency and overflow / invalid-opcode exceptions.
module multicycle_control_fsm
  import mcpu_ctrl_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter bit OVF_EXC_EN  = 1'b1
) (
  input logic clk,
  input logic reset,
  multicycle_control_fsm_if.master bus
);
  state_t state, nextState;
  logic cntDone, isRAlu, isAddSub;
  assign isRAlu   = bus.funct inside {FN_ADD, FN_SUB, FN_AND, FN_XOR};
  assign isAddSub = bus.funct inside {FN_ADD, FN_SUB};
  // Both memory waits share one counter: the issuing state loads it, the wait state drains it.
  mem_wait_counter #(.LOAD(MEM_LATENCY - 1)) waitCnt (
    .clk(clk),
    .reset(reset),
    .load(state == FETCH || state == LW_RD),
    .count(state == MEM_WAIT || state == LW_WAIT),
    .done(cntDone)
  );
  always_ff @(posedge clk) state <= reset ? RESET : nextState;
  always_comb begin
    nextState          = state;
    bus.memWriteOrRead = 1'b0;
    bus.iorD           = 1'b0;
    bus.irWrite        = 1'b0;
    bus.mdrWrite       = 1'b0;
    bus.pcControl      = 1'b0;
    bus.pcCond         = 1'b0;
    bus.bneORbeq       = 1'b0;
    bus.origPC         = PC_ALU;
    bus.writeA         = 1'b0;
    bus.writeB         = 1'b0;
    bus.aluSrcA        = 1'b0;
    bus.aluSrcB        = 2'b00;
    bus.aluControl     = 3'b000;
    bus.aluOutControl  = 1'b0;
    bus.regWrite       = 1'b0;
    bus.regDst         = 1'b0;
    bus.memToReg       = M2R_ALUOUT;
    bus.epcWrite       = 1'b0;
    bus.halted         = 1'b0;
    bus.estado         = state;
    case (state)
      RESET:    nextState = FETCH;
      FETCH:    nextState = MEM_WAIT;
      MEM_WAIT: nextState = cntDone ? IR_WRITE : MEM_WAIT;
      IR_WRITE: begin
        bus.irWrite    = 1'b1;
        bus.pcControl  = 1'b1;
        bus.aluSrcB    = 2'b01;
        bus.aluControl = ALU_ADD;
        bus.origPC     = PC_ALU;
        nextState      = DECODE;
      end
      DECODE: begin
        bus.writeA        = 1'b1;
        bus.writeB        = 1'b1;
        bus.aluSrcB       = 2'b11;
        bus.aluControl    = ALU_ADD;
        bus.aluOutControl = 1'b1;
        nextState = bus.opcode == OP_RTYPE ?
                      (isRAlu ? EXEC_R : bus.funct == FN_NOP ? FETCH : bus.funct == FN_BREAK ? BREAK : EXC) :
                    bus.opcode inside {OP_BEQ, OP_BNE} ? BRANCH :
                    bus.opcode inside {OP_LW, OP_SW}   ? ADDR :
                    bus.opcode == OP_LUI ? LUI_WB :
                    bus.opcode == OP_J   ? JUMP : EXC;
      end
      EXEC_R: begin
        bus.aluSrcA       = 1'b1;
        bus.aluControl    = functAlu(bus.funct);
        bus.aluOutControl = 1'b1;
        nextState = (bus.aluOverflow && OVF_EXC_EN && isAddSub) ? EXC : WB_R;
      end
      WB_R: begin
        bus.regWrite = 1'b1;
        bus.regDst   = 1'b1;
        nextState    = FETCH;
      end
      BRANCH: begin
        bus.aluSrcA    = 1'b1;
        bus.aluControl = ALU_SUB;
        bus.pcCond     = 1'b1;
        bus.origPC     = PC_ALUOUT;
        bus.bneORbeq   = bus.opcode == OP_BEQ;
        nextState      = FETCH;
      end
      ADDR: begin
        bus.aluSrcA       = 1'b1;
        bus.aluSrcB       = 2'b10;
        bus.aluControl    = ALU_ADD;
        bus.aluOutControl = 1'b1;
        nextState         = bus.opcode == OP_LW ? LW_RD : SW_WR;
      end
      LW_RD: begin
        bus.iorD  = 1'b1;
        nextState = LW_WAIT;
      end
      LW_WAIT: begin
        bus.iorD     = 1'b1;
        bus.mdrWrite = cntDone;
        nextState    = cntDone ? LW_WB : LW_WAIT;
      end
      LW_WB: begin
        bus.regWrite = 1'b1;
        bus.memToReg = M2R_MDR;
        nextState    = FETCH;
      end
      SW_WR: begin
        bus.iorD           = 1'b1;
        bus.memWriteOrRead = 1'b1;
        nextState          = FETCH;
      end
      LUI_WB: begin
        bus.regWrite = 1'b1;
        bus.memToReg = M2R_LUI;
        nextState    = FETCH;
      end
      JUMP: begin
        bus.pcControl = 1'b1;
        bus.origPC    = PC_JUMP;
        nextState     = FETCH;
      end
      EXC: begin
        bus.epcWrite  = 1'b1;
        bus.pcControl = 1'b1;
        bus.origPC    = PC_EXC;
        nextState     = FETCH;
      end
      BREAK:   bus.halted = 1'b1;
      default: nextState = RESET;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: three lanes (latency 2/3/1, last with overflow exceptions off)
// run the same instructions and are compared cycle by cycle against an expected control trace.
module tb_multicycle_control_fsm;
  import mcpu_ctrl_pkg::*;
  typedef struct packed {
    logic mwr, iord, irw, mdrw, pcc, pcCnd, bne;
    logic [1:0] opc;
    logic wa, wb, sa;
    logic [1:0] sb;
    logic [2:0] alu;
    logic aoc, rw, rd;
    logic [1:0] m2r;
    logic epc, halt;
    logic [4:0] st;
  } ctl_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic aluOverflow = 1'b0;
  logic aluZero = 1'b0;
  int errors = 0;
  int checks = 0;
  ctl_t obs [3];
  ctl_t expTr [3][64];
  int expLen [3];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : lane
    multicycle_control_fsm_if bus ();
    assign bus.opcode = opcode;
    assign bus.funct = funct;
    assign bus.aluZero = aluZero;
    assign bus.aluOverflow = aluOverflow;
    multicycle_control_fsm #(.MEM_LATENCY(g == 0 ? 2 : g == 1 ? 3 : 1), .OVF_EXC_EN(g != 2)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.master)
    );
    assign obs[g] = {bus.memWriteOrRead, bus.iorD, bus.irWrite, bus.mdrWrite, bus.pcControl,
                     bus.pcCond, bus.bneORbeq, bus.origPC, bus.writeA, bus.writeB, bus.aluSrcA,
                     bus.aluSrcB, bus.aluControl, bus.aluOutControl, bus.regWrite, bus.regDst,
                     bus.memToReg, bus.epcWrite, bus.halted, bus.estado};
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask
  function automatic ctl_t at(input state_t s);
    ctl_t c = '0;
    c.st = s;
    return c;
  endfunction
  function automatic logic [2:0] aluCode(input logic [5:0] f);
    case (f)
      6'h22:   return 3'b010;
      6'h24:   return 3'b011;
      6'h26:   return 3'b110;
      default: return 3'b001;
    endcase
  endfunction
  task automatic push(input int k, input ctl_t c);
    expTr[k][expLen[k]] = c;
    expLen[k]++;
  endtask
  // Expected per-cycle control words from the reset cycle to the return to FETCH.
  task automatic build(input int k);
    int lat = k == 0 ? 2 : k == 1 ? 3 : 1;
    bit ovfEn = k != 2;
    ctl_t c;
    expLen[k] = 0;
    push(k, at(RESET));
    push(k, at(FETCH));
    repeat (lat) push(k, at(MEM_WAIT));
    c = at(IR_WRITE); c.irw = 1; c.pcc = 1; c.sb = 2'b01; c.alu = 3'b001; push(k, c);
    c = at(DECODE); c.wa = 1; c.wb = 1; c.sb = 2'b11; c.alu = 3'b001; c.aoc = 1; push(k, c);
    if (opcode == 6'h00 && funct inside {6'h20, 6'h22, 6'h24, 6'h26}) begin
      c = at(EXEC_R); c.sa = 1; c.alu = aluCode(funct); c.aoc = 1; push(k, c);
      if (aluOverflow && ovfEn && funct inside {6'h20, 6'h22}) begin
        c = at(EXC); c.epc = 1; c.pcc = 1; c.opc = 2'b11; push(k, c);
      end else begin
        c = at(WB_R); c.rw = 1; c.rd = 1; push(k, c);
      end
    end else if (opcode == 6'h00 && funct == 6'h0D) begin
      repeat (20) begin c = at(BREAK); c.halt = 1; push(k, c); end
      return;
    end else if (opcode == 6'h00 && funct == 6'h00) begin
    end else if (opcode == 6'h04 || opcode == 6'h05) begin
      c = at(BRANCH); c.sa = 1; c.alu = 3'b010; c.pcCnd = 1; c.opc = 2'b01;
      c.bne = opcode == 6'h04; push(k, c);
    end else if (opcode == 6'h23 || opcode == 6'h2B) begin
      c = at(ADDR); c.sa = 1; c.sb = 2'b10; c.alu = 3'b001; c.aoc = 1; push(k, c);
      if (opcode == 6'h23) begin
        c = at(LW_RD); c.iord = 1; push(k, c);
        for (int i = 1; i <= lat; i++) begin c = at(LW_WAIT); c.iord = 1; c.mdrw = i == lat; push(k, c); end
        c = at(LW_WB); c.rw = 1; c.m2r = 2'b01; push(k, c);
      end else begin
        c = at(SW_WR); c.iord = 1; c.mwr = 1; push(k, c);
      end
    end else if (opcode == 6'h0F) begin
      c = at(LUI_WB); c.rw = 1; c.m2r = 2'b10; push(k, c);
    end else if (opcode == 6'h02) begin
      c = at(JUMP); c.pcc = 1; c.opc = 2'b10; push(k, c);
    end else begin
      c = at(EXC); c.epc = 1; c.pcc = 1; c.opc = 2'b11; push(k, c);
    end
    push(k, at(FETCH));
  endtask
  task automatic runInstr(input string name, input logic [5:0] op, input logic [5:0] fn,
                          input logic ovf, input logic zero);
    int maxLen = 0;
    opcode = op; funct = fn; aluOverflow = ovf; aluZero = zero;
    for (int k = 0; k < 3; k++) begin
      build(k);
      if (expLen[k] > maxLen) maxLen = expLen[k];
    end
    @(negedge clk) reset = 1'b1;
    for (int c = 0; c < maxLen; c++) begin
      @(negedge clk) reset = 1'b0;
      for (int k = 0; k < 3; k++)
        if (c < expLen[k]) check($sformatf("%s lane%0d cyc%0d", name, k, c), 32'(obs[k]), 32'(expTr[k][c]));
    end
  endtask
  logic [5:0] opPool [7] = '{6'h00, 6'h04, 6'h05, 6'h23, 6'h2B, 6'h0F, 6'h02};
  logic [5:0] fnPool [6] = '{6'h20, 6'h22, 6'h24, 6'h26, 6'h00, 6'h0D};
  initial begin
    runInstr("add", 6'h00, 6'h20, 1'b0, 1'b0);
    runInstr("beq", 6'h04, 6'h00, 1'b0, 1'b1);
    runInstr("bne", 6'h05, 6'h00, 1'b0, 1'b1);
    runInstr("lw", 6'h23, 6'h00, 1'b0, 1'b0);
    runInstr("sw", 6'h2B, 6'h00, 1'b0, 1'b0);
    runInstr("addOvf", 6'h00, 6'h20, 1'b1, 1'b0);
    runInstr("subOvf", 6'h00, 6'h22, 1'b1, 1'b0);
    runInstr("andOvf", 6'h00, 6'h24, 1'b1, 1'b0);
    runInstr("xor", 6'h00, 6'h26, 1'b0, 1'b0);
    runInstr("lui", 6'h0F, 6'h00, 1'b0, 1'b0);
    runInstr("j", 6'h02, 6'h00, 1'b0, 1'b0);
    runInstr("nop", 6'h00, 6'h00, 1'b0, 1'b0);
    runInstr("badOp", 6'h3F, 6'h00, 1'b0, 1'b0);
    runInstr("badFn", 6'h00, 6'h21, 1'b0, 1'b0);
    runInstr("break", 6'h00, 6'h0D, 1'b0, 1'b0);
    runInstr("afterBreak", 6'h00, 6'h22, 1'b0, 1'b0);
    // Reset landing in the middle of the fetch wait on every lane.
    opcode = 6'h00; funct = 6'h20; aluOverflow = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) check($sformatf("preReset lane%0d", k), 32'(obs[k].st), 32'(MEM_WAIT));
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    for (int k = 0; k < 3; k++) check($sformatf("midWaitReset lane%0d", k), 32'(obs[k]), 32'(at(RESET)));
    @(negedge clk);
    for (int k = 0; k < 3; k++) check($sformatf("postReset lane%0d", k), 32'(obs[k]), 32'(at(FETCH)));
    for (int n = 0; n < 60; n++) begin
      int po = $urandom_range(0, 7);
      int pf = $urandom_range(0, 6);
      runInstr($sformatf("rnd%0d", n), po == 7 ? 6'($urandom) : opPool[po],
               pf == 6 ? 6'($urandom) : fnPool[pf], 1'($urandom), 1'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
